fifo_sync_prog: RTL and testbench
=================================

Name: fifo_sync_prog

Overview:
Parametrised single-clock synchronous FIFO and successor to the team's fixed-threshold FIFO. Adds:
- non-power-of-two depth with explicit pointer wrap
- runtime-programmable almost-full/almost-empty levels
- occupancy output
- defined pass-through on simultaneous read/write at full
- read-data valid strobe

Sits between producer/consumer datapaths in the same clock domain.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (1..256)
- FIFO_DEPTH, 8, number of entries (2..1024, need not be a power of two)
- CNT_W, $clog2(FIFO_DEPTH+1), width of count and level ports (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_in  in  FIFO_WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read request
- af_level  in  CNT_W  almost-full threshold, quasi-static
- ae_level  in  CNT_W  almost-empty threshold, quasi-static
- data_out  out  FIFO_WIDTH  read data
- rd_valid  out  1  data_out updated by a read accepted last edge
- wr_ack  out  1  write accepted last edge
- overflow  out  1  write rejected last edge
- underflow  out  1  read rejected last edge
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almostfull  out  1  count >= af_level
- almostempty  out  1  count <= ae_level
- count  out  CNT_W  current occupancy

Behaviour:
Reset (async assert, sync-to-clk deassert by system):
- wr_ptr, rd_ptr, count = 0
- data_out = 0
- rd_valid, wr_ack, overflow, underflow = 0
- Memory not cleared
- Flags follow count: empty=1, full=0; almostempty/almostfull per levels

Acceptance (evaluated on pre-edge state):
- rd_acc = rd_en && count != 0
- wr_acc = wr_en && (count < FIFO_DEPTH || rd_acc). Full plus simultaneous read is a pass-through; both are accepted.
- Empty with both asserted: write accepted, read rejected, underflow=1.

Count update:
- +1 if wr_acc && !rd_acc
- -1 if rd_acc && !wr_acc
- otherwise unchanged
- Never exceeds FIFO_DEPTH or goes below 0.

Pointers:
- Increment on acceptance.
- At FIFO_DEPTH-1, wrap to 0 explicitly. No modulo-2^n reliance.

Read latency (standard mode):
- Accepted read at edge N presents mem[rd_ptr] on data_out after edge N.
- rd_valid=1 for exactly one cycle.
- data_out holds its value otherwise.

Strobes:
- wr_ack, overflow, underflow are registered single-cycle strobes reflecting the edge just taken.
- overflow = wr_en && !wr_acc
- underflow = rd_en && !rd_acc

Flags and thresholds:
- full, empty, almostfull, almostempty, count are combinational from the count register. No extra latency.
- af_level=0 forces almostfull=1.
- ae_level >= FIFO_DEPTH forces almostempty=1.
- Threshold changes take effect the same cycle.

Reset mid-operation:
- All state above clears immediately.
- Strobes drop asynchronously.
- First accepted write after deassert lands in entry 0.

Optional Feature:
Macro FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out = mem[rd_ptr] combinationally while count != 0; 0 when empty.
  - rd_valid = !empty.
  - rd_en pops the shown word; same acceptance and underflow rules as standard mode.
  - A write to an empty FIFO is visible on data_out one cycle after the write edge.
- Undefined: standard registered read as in Behaviour.
- Ports identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_w(depth) returning max(1, $clog2(depth))
  - function cnt_w(depth) returning $clog2(depth+1)
  - localparam limits FIFO_DEPTH_MIN=2, FIFO_DEPTH_MAX=1024
- Sub-module fifo_wrap_ptr:
  - Parameterised by DEPTH.
  - Inputs: clk, rst_n, inc. Output: ptr.
  - Wraps at DEPTH-1.
  - Instantiated twice (write and read pointer).

Test Plan:
Bench uses FIFO_WIDTH=16, FIFO_DEPTH=6, af_level=5, ae_level=1, standard mode unless noted.
1. Reset, then write 0x0001..0x0006 on consecutive cycles.
   - wr_ack each cycle; count 1..6.
   - almostfull asserts at count 5; full at 6.
   - 7th write gives overflow=1, wr_ack=0, count stays 6.
2. From full, assert wr_en=rd_en=1 with data 0x00AA.
   - wr_ack=1, rd_valid=1, data_out=0x0001, count stays 6, no overflow.
3. Drain fully.
   - data_out sequence is 0x0002..0x0006 then 0x00AA, proving pointer wrap at entry 5→0.
   - empty=1; an extra rd_en gives underflow=1 and data_out unchanged.
4. Empty FIFO, wr_en=rd_en=1 with data 0x1234.
   - wr_ack=1, underflow=1, rd_valid=0, count becomes 1, almostempty=1.
5. Fill 3 entries, pulse rst_n low mid-cycle.
   - count=0, empty=1, all strobes 0 immediately.
   - Next write/read returns the newly written word.
6. FIFO_FWFT_EN build: write 0x00BE into empty.
   - Next cycle data_out=0x00BE, rd_valid=1 without rd_en.
   - rd_en pops it: empty=1, data_out=0.

Source files
------------

// File: rtl/fifo_sync_prog_pkg.sv
// Shared sizing helpers and depth limits for the programmable synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 1024;

  // A depth of 1 would give a zero-width pointer, so the pointer is never narrower than 1 bit.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Producer/consumer bus of fifo_sync_prog; master drives requests, slave is the FIFO.
interface fifo_sync_prog_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  import fifo_pkg::*;

  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_level;
  logic [CNT_W-1:0]      ae_level;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output data_in, wr_en, rd_en, af_level, ae_level,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en, af_level, ae_level,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_sync_prog_wrap_ptr.sv
// Circular pointer for a FIFO of arbitrary depth; wraps from DEPTH-1 back to 0 explicitly.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  output logic [ptr_w(DEPTH)-1:0] ptr
);

  localparam int PTR_W = ptr_w(DEPTH);

  // Non-power-of-two depths cannot rely on natural binary rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty levels and full pass-through.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads are registered.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_prog_if.slave  bus
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int PTR_W = ptr_w(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;

  // A read frees a slot on the same edge, so a full FIFO still accepts a write alongside it.
  assign rd_acc = bus.rd_en && (count_q != '0);
  assign wr_acc = bus.wr_en && ((count_q < CNT_W'(FIFO_DEPTH)) || rd_acc);

  fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count_q <= count_q - CNT_W'(1);
      end
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en && !wr_acc;
      underflow_q <= bus.rd_en && !rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = (count_q != '0) ? mem[rd_ptr] : '0;
  assign bus.rd_valid = (count_q != '0);
`else
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q;

  // Memory is sampled before the same-edge write lands, so pass-through at full returns the oldest word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        data_out_q <= mem[rd_ptr];
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign bus.empty       = (count_q == '0);
  assign bus.almostfull  = (count_q >= bus.af_level);
  assign bus.almostempty = (count_q <= bus.ae_level);

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: directed scenarios then random traffic vs a queue model.
module tb_fifo_sync_prog;

  localparam int W  = 16;
  localparam int D  = 6;
  localparam int CW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_prog_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus ();

  fifo_sync_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  q[$];
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ack;
  logic          m_ovf;
  logic          m_udf;
  logic [CW-1:0] af_lvl;
  logic [CW-1:0] ae_lvl;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ack   = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    int           n;
    logic [W-1:0] exp_data;
    logic         exp_valid;
    n = q.size();
`ifdef FIFO_FWFT_EN
    exp_data  = (n != 0) ? q[0] : '0;
    exp_valid = (n != 0);
`else
    exp_data  = m_data;
    exp_valid = m_valid;
`endif
    checkOutput({tag, ":count"},       32'(bus.count),       32'(n));
    checkOutput({tag, ":full"},        32'(bus.full),        32'(n == D));
    checkOutput({tag, ":empty"},       32'(bus.empty),       32'(n == 0));
    checkOutput({tag, ":almostfull"},  32'(bus.almostfull),  32'(n >= int'(af_lvl)));
    checkOutput({tag, ":almostempty"}, 32'(bus.almostempty), 32'(n <= int'(ae_lvl)));
    checkOutput({tag, ":wr_ack"},      32'(bus.wr_ack),      32'(m_ack));
    checkOutput({tag, ":overflow"},    32'(bus.overflow),    32'(m_ovf));
    checkOutput({tag, ":underflow"},   32'(bus.underflow),   32'(m_udf));
    checkOutput({tag, ":rd_valid"},    32'(bus.rd_valid),    32'(exp_valid));
    checkOutput({tag, ":data_out"},    32'(bus.data_out),    32'(exp_data));
  endtask

  // Inputs change on the falling edge; the model advances on the rising edge, outputs are checked 1ns later.
  task automatic applyStimulus(input logic w, input logic r, input logic [W-1:0] d, input string tag);
    logic rd_acc;
    logic wr_acc;
    @(negedge clk);
    bus.wr_en    = w;
    bus.rd_en    = r;
    bus.data_in  = d;
    bus.af_level = af_lvl;
    bus.ae_level = ae_lvl;
    @(posedge clk);
    rd_acc  = r && (q.size() != 0);
    wr_acc  = w && ((q.size() < D) || rd_acc);
    m_valid = rd_acc;
    if (rd_acc) m_data = q.pop_front();
    if (wr_acc) q.push_back(d);
    m_ack = wr_acc;
    m_ovf = w && !wr_acc;
    m_udf = r && !rd_acc;
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [W-1:0] drain_exp [6];
    int           wr_pct;
    int           rd_pct;

    drain_exp    = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h00AA};
    af_lvl       = 3'd5;
    ae_lvl       = 3'd1;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.data_in  = '0;
    bus.af_level = af_lvl;
    bus.ae_level = ae_lvl;
    modelReset();
    #2;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, W'(i), "t1_fill");
    checkOutput("t1_full_at6", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0007, "t1_ovf");
    checkOutput("t1_ovf_strobe", 32'(bus.overflow), 32'd1);

    applyStimulus(1'b1, 1'b1, 16'h00AA, "t2_pass");
    checkOutput("t2_pass_ack", 32'(bus.wr_ack), 32'd1);
`ifndef FIFO_FWFT_EN
    checkOutput("t2_pass_data", 32'(bus.data_out), 32'h0001);
`endif

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, '0, "t3_drain");
`ifndef FIFO_FWFT_EN
      checkOutput("t3_wrap_seq", 32'(bus.data_out), 32'(drain_exp[i]));
`endif
    end
    applyStimulus(1'b0, 1'b1, '0, "t3_udf");
    checkOutput("t3_udf_strobe", 32'(bus.underflow), 32'd1);

    applyStimulus(1'b1, 1'b1, 16'h1234, "t4_both_empty");
    checkOutput("t4_count", 32'(bus.count), 32'd1);

    applyStimulus(1'b0, 1'b1, '0, "t5_pre");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, W'(16'h0100 + i), "t5_fill");
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("t5_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h5A5A, "t5_wr");
    applyStimulus(1'b0, 1'b1, '0, "t5_rd");
`ifndef FIFO_FWFT_EN
    checkOutput("t5_entry0", 32'(bus.data_out), 32'h5A5A);
`endif

`ifdef FIFO_FWFT_EN
    applyStimulus(1'b1, 1'b0, 16'h00BE, "t6_fwft_wr");
    checkOutput("t6_fwft_data", 32'(bus.data_out), 32'h00BE);
    checkOutput("t6_fwft_valid", 32'(bus.rd_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, '0, "t6_fwft_pop");
    checkOutput("t6_fwft_zero", 32'(bus.data_out), 32'h0);
`endif

    // Bias alternates between filling and draining so both boundaries are reached repeatedly.
    wr_pct = 50;
    rd_pct = 50;
    for (int c = 0; c < 400; c++) begin
      if (c % 40 == 0) begin
        af_lvl = CW'($urandom_range(0, 7));
        ae_lvl = CW'($urandom_range(0, 7));
        wr_pct = ((c / 40) % 2 == 0) ? 80 : 25;
        rd_pct = 100 - wr_pct;
      end
      applyStimulus(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
                    W'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
